sieve_param: RTL and testbench

SIEVE_PARAM -- requirements
Module: sieve_param

---
 rtl/sieve_pkg.sv | 19 +
 rtl/sieve_rd_pipe.sv | 29 ++
 rtl/sieve_param.sv | 161 ++++++++++++++++
 tb/tb_sieve_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sieve_pkg.sv
// rtl/sieve_pkg.sv - shared state encoding and bitmap constants for the sieve engine
package sieve_pkg;

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      CHK_RD,
      CHK_WAIT,
      MARK,
      SCAN_RD,
      SCAN_WAIT,
      EMIT,
      DONE
   } state_e;

   localparam logic CAND = 1'b0;
   localparam logic COMP = 1'b1;

endpackage

// File: rtl/sieve_rd_pipe.sv
// rtl/sieve_rd_pipe.sv - read-valid tag pipeline matching the external bitmap read latency
module sieve_rd_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic rd_issue,
   output logic rd_valid
);

   logic [RD_LAT-1:0] tag_q;
   logic [RD_LAT-1:0] tag_d;

   always_comb begin
      tag_d    = tag_q << 1;
      tag_d[0] = rd_issue;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q <= '0;
      end else begin
         tag_q <= tag_d;
      end
   end

   assign rd_valid = tag_q[RD_LAT-1];

endmodule

// File: rtl/sieve_param.sv
// rtl/sieve_param.sv - Sieve of Eratosthenes engine over an external 1-bit bitmap memory
module sieve_param
   import sieve_pkg::*;
#(
   parameter int W      = 8,
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] limit,
   output logic         mem_we,
   output logic [W-1:0] mem_addr,
   output logic         mem_wdata,
   input  logic         mem_rdata,
   output logic         prime_valid,
   input  logic         prime_ready,
   output logic [W-1:0] prime_data,
   output logic [W-1:0] prime_count,
   output logic         busy,
   output logic         done
);

   localparam logic [W:0] TWO = (W+1)'(2);

   state_e       state_q, state_d;
   logic [W:0]   lim_q, lim_d;
   logic [W:0]   i_q, i_d;
   logic [W:0]   addr_q, addr_d;
   logic [W-1:0] prime_data_q, prime_data_d;
   logic [W-1:0] prime_count_q, prime_count_d;
   logic [W:0]   two_i;
   logic [W:0]   j_next;
   logic         rd_issue;
   logic         rd_valid;

   // All loop bounds are compared one bit wider than the bitmap so limit = 2^W-1 never wraps.
   assign two_i  = i_q << 1;
   assign j_next = addr_q + i_q;

   sieve_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .rd_issue (rd_issue),
      .rd_valid (rd_valid)
   );

   always_comb begin
      state_d       = state_q;
      lim_d         = lim_q;
      i_d           = i_q;
      addr_d        = addr_q;
      prime_data_d  = prime_data_q;
      prime_count_d = prime_count_q;
      rd_issue      = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               lim_d         = {1'b0, limit};
               addr_d        = '0;
               prime_count_d = '0;
               state_d       = CLEAR;
            end
         end
         CLEAR: begin
            if (addr_q >= lim_q) begin
               i_d     = TWO;
               state_d = CHK_RD;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         CHK_RD: begin
            if (two_i > lim_q) begin
               addr_d  = TWO;
               state_d = SCAN_RD;
            end else begin
               rd_issue = 1'b1;
               state_d  = CHK_WAIT;
            end
         end
         CHK_WAIT: begin
            if (rd_valid) begin
               if (mem_rdata == COMP) begin
                  i_d     = i_q + 1'b1;
                  state_d = CHK_RD;
               end else begin
                  addr_d  = two_i;
                  state_d = MARK;
               end
            end
         end
         MARK: begin
            // Entry guarantees addr_q <= limit, so every MARK cycle is a legal write.
            addr_d = j_next;
            if (j_next > lim_q) begin
               i_d     = i_q + 1'b1;
               state_d = CHK_RD;
            end
         end
         SCAN_RD: begin
            if (addr_q > lim_q) begin
               state_d = DONE;
            end else begin
               rd_issue = 1'b1;
               state_d  = SCAN_WAIT;
            end
         end
         SCAN_WAIT: begin
            if (rd_valid) begin
               if (mem_rdata == CAND) begin
                  prime_data_d = addr_q[W-1:0];
                  state_d      = EMIT;
               end else begin
                  addr_d  = addr_q + 1'b1;
                  state_d = SCAN_RD;
               end
            end
         end
         EMIT: begin
            if (prime_ready) begin
               prime_count_d = prime_count_q + 1'b1;
               addr_d        = addr_q + 1'b1;
               state_d       = SCAN_RD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         lim_q         <= '0;
         i_q           <= '0;
         addr_q        <= '0;
         prime_data_q  <= '0;
         prime_count_q <= '0;
      end else begin
         state_q       <= state_d;
         lim_q         <= lim_d;
         i_q           <= i_d;
         addr_q        <= addr_d;
         prime_data_q  <= prime_data_d;
         prime_count_q <= prime_count_d;
      end
   end

   // Write enable is masked by rst so an abort stops writes in the very cycle it is raised.
   assign mem_we      = ((state_q == CLEAR) || (state_q == MARK)) && !rst;
   assign mem_wdata   = (state_q == MARK) ? COMP : CAND;
   assign mem_addr    = ((state_q == CHK_RD) || (state_q == CHK_WAIT)) ? i_q[W-1:0] : addr_q[W-1:0];
   assign prime_valid = (state_q == EMIT);
   assign prime_data  = prime_data_q;
   assign prime_count = prime_count_q;
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_sieve_param.sv
// tb/tb_sieve_param.sv - self-checking bench for sieve_param at read latencies 1 and 2
module tb_sieve_param;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         prime_ready;
   logic [W-1:0] limit;
   logic [1:0]   mem_we, mem_wdata, mem_rdata, prime_valid, busy, done;
   logic [W-1:0] mem_addr [2];
   logic [W-1:0] prime_data [2];
   logic [W-1:0] prime_count [2];

   always #5 clk = ~clk;

   sieve_param #(.W(W), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .limit(limit),
      .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
      .prime_valid(prime_valid[0]), .prime_ready(prime_ready), .prime_data(prime_data[0]),
      .prime_count(prime_count[0]), .busy(busy[0]), .done(done[0])
   );

   sieve_param #(.W(W), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .limit(limit),
      .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
      .prime_valid(prime_valid[1]), .prime_ready(prime_ready), .prime_data(prime_data[1]),
      .prime_count(prime_count[1]), .busy(busy[1]), .done(done[1])
   );

   // Bitmap memories: read data appears 1 (dut1) or 2 (dut2) cycles after the address.
   logic       mem [2][256];
   logic [1:0] rd_s1, rd_s2;
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
         rd_s1[d] <= mem[d][mem_addr[d]];
         rd_s2[d] <= rd_s1[d];
      end
   end
   assign mem_rdata = {rd_s2[1], rd_s1[0]};

   int ready_pct = 100;
   always @(posedge clk) begin
      #1;
      prime_ready = ($urandom_range(0, 99) < ready_pct);
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         lim_cur = 0;
   int         got [2][64];
   int         ngot [2];
   int         viol [2];
   int         zero_wr [2];
   int         last_clr [2];
   int         done_at [2];
   logic [1:0] stall;
   logic [W-1:0] held [2];

   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (mem_we[d]) begin
            if (int'(mem_addr[d]) > lim_cur) viol[d]++;
            if (prime_valid[d]) viol[d]++;
            if (!mem_wdata[d]) begin
               zero_wr[d]++;
               last_clr[d] = cyc;
            end
         end
         if (stall[d] && (!prime_valid[d] || prime_data[d] !== held[d])) viol[d]++;
         if (prime_valid[d] && prime_ready && ngot[d] < 64) begin
            got[d][ngot[d]] = int'(prime_data[d]);
            ngot[d]++;
         end
         stall[d] = prime_valid[d] && !prime_ready;
         held[d]  = prime_data[d];
         if (done[d] && done_at[d] < 0) done_at[d] = cyc;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit is_prime(input int n);
      if (n < 2) return 1'b0;
      for (int k = 2; k * k <= n; k++) if (n % k == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic pulse_start(input int lim);
      limit = lim[W-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // exp_n < 0 means "no table expectation", only the reference model is used.
   task automatic run_case(input int lim, input int pct, input int exp_n, input int exp_last, input bit interfere);
      int refp [64];
      int n_ref;
      int cnt;
      int seq_bad;
      n_ref = 0;
      for (int n = 2; n <= lim; n++) if (is_prime(n)) begin refp[n_ref] = n; n_ref++; end
      for (int d = 0; d < 2; d++) begin
         ngot[d] = 0; viol[d] = 0; zero_wr[d] = 0; done_at[d] = -1; last_clr[d] = 0; stall[d] = 1'b0;
      end
      lim_cur   = lim;
      ready_pct = pct;
      @(posedge clk); #1;
      pulse_start(lim);
      if (interfere) begin
         repeat (15) @(posedge clk);
         #1;
         pulse_start(50);
      end
      cnt = 0;
      while (done !== 2'b11 && cnt < 20000) begin
         @(posedge clk);
         cnt++;
      end
      @(negedge clk);
      check($sformatf("timeout lim=%0d", lim), int'(cnt < 20000), 1);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("n_primes lat%0d lim=%0d", d + 1, lim), ngot[d], n_ref);
         if (exp_n >= 0) check($sformatf("tbl_count lat%0d lim=%0d", d + 1, lim), ngot[d], exp_n);
         if (exp_n > 0 && ngot[d] > 0) check($sformatf("last lat%0d lim=%0d", d + 1, lim), got[d][ngot[d]-1], exp_last);
         seq_bad = 0;
         for (int k = 0; k < n_ref && k < ngot[d]; k++) if (got[d][k] != refp[k]) seq_bad++;
         check($sformatf("sequence lat%0d lim=%0d", d + 1, lim), seq_bad, 0);
         check($sformatf("prime_count lat%0d lim=%0d", d + 1, lim), int'(prime_count[d]), n_ref);
         check($sformatf("busy lat%0d lim=%0d", d + 1, lim), int'(busy[d]), 0);
         check($sformatf("done lat%0d lim=%0d", d + 1, lim), int'(done[d]), 1);
         check($sformatf("violations lat%0d lim=%0d", d + 1, lim), viol[d], 0);
         check($sformatf("clear_writes lat%0d lim=%0d", d + 1, lim), zero_wr[d], lim + 1);
         if (lim < 2) check($sformatf("done_latency_ok lat%0d", d + 1), int'(done_at[d] - last_clr[d] <= 4), 1);
      end
   endtask

   typedef struct {
      int lim;
      int pct;
      int n;
      int last;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int cnt;
      tbl[0] = '{10, 100, 4, 7};
      tbl[1] = '{30, 33, 10, 29};
      tbl[2] = '{1, 100, 0, 0};
      tbl[3] = '{255, 60, 54, 251};
      tbl[4] = '{2, 50, 1, 2};
      tbl[5] = '{0, 100, 0, 0};
      tbl[6] = '{4, 100, 2, 3};
      tbl[7] = '{100, 80, 25, 97};

      rst = 1'b1; start = 1'b0; limit = '0; prime_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst busy lat%0d", d + 1), int'(busy[d]), 0);
         check($sformatf("rst done lat%0d", d + 1), int'(done[d]), 0);
         check($sformatf("rst prime_valid lat%0d", d + 1), int'(prime_valid[d]), 0);
         check($sformatf("rst mem_we lat%0d", d + 1), int'(mem_we[d]), 0);
         check($sformatf("rst mem_wdata lat%0d", d + 1), int'(mem_wdata[d]), 0);
         check($sformatf("rst mem_addr lat%0d", d + 1), int'(mem_addr[d]), 0);
         check($sformatf("rst prime_data lat%0d", d + 1), int'(prime_data[d]), 0);
         check($sformatf("rst prime_count lat%0d", d + 1), int'(prime_count[d]), 0);
      end
      rst = 1'b0;

      for (int v = 0; v < 8; v++) run_case(tbl[v].lim, tbl[v].pct, tbl[v].n, tbl[v].last, 1'b0);

      // start while busy is ignored, then a fresh start after done
      run_case(30, 100, 10, 29, 1'b1);
      run_case(12, 100, 5, 11, 1'b0);

      // reset in the middle of marking
      lim_cur = 100;
      @(posedge clk); #1;
      pulse_start(100);
      cnt = 0;
      @(negedge clk);
      while (!(mem_we[0] && mem_wdata[0]) && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check("reach_mark", int'(cnt < 2000), 1);
      rst = 1'b1;
      #1;
      check("rst_blocks_write", int'(mem_we), 0);
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_count", int'(prime_count[0]), 0);
      rst = 1'b0;
      run_case(20, 100, 8, 19, 1'b0);

      for (int r = 0; r < 4; r++) run_case($urandom_range(2, 255), $urandom_range(20, 100), -1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
